// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared block/key types, controller states and timing constants for the DES CBC front end
package des_pkg;

  typedef logic [63:0] des_blk_t;
  typedef logic [63:0] des_key_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } des_ctrl_st_e;

  localparam int DES_ROUNDS = 16;
  // handshake -> issue -> 16 busy rounds -> Dvld -> registered output
  localparam int DES_LAT    = DES_ROUNDS + 3;

endpackage

// File: rtl/des_cbc_ctrl.sv
// rtl/des_cbc_ctrl.sv - CBC/ECB chaining and handshake sequencer around the iterative DES core
// Optional CBC datapath is built only when DES_CBC_EN is defined; otherwise every block is ECB.
module des_cbc_ctrl
  import des_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] Key,
  input  logic [63:0] Iv,
  input  logic        Enc,
  input  logic        Cbc,
  input  logic        CfgLd,
  output logic        CfgRdy,
  input  logic [63:0] InData,
  input  logic        InVld,
  output logic        InRdy,
  output logic [63:0] OutData,
  output logic        OutVld,
  input  logic        OutRdy,
  output logic        Busy,
  output logic [63:0] DesDin,
  output logic [63:0] DesKey,
  output logic        DesDrdy,
  output logic        DesKrdy,
  output logic        DesEnc,
  output logic        DesEn,
  input  logic [63:0] DesDout,
  input  logic        DesBsy,
  input  logic        DesDvld
);

  des_ctrl_st_e state_q, state_d;
  des_blk_t     buf_q, buf_d;
  des_blk_t     out_q, out_d;
  des_key_t     key_q, key_d;
  logic         buf_full_q, buf_full_d;
  logic         enc_q, enc_d;
  logic         key_pend_q, key_pend_d;
  logic         in_hs, cfg_hs, issue;

`ifdef DES_CBC_EN
  logic         cbc_q, cbc_d;
  des_blk_t     chain_q, chain_d;
  des_blk_t     ct_save_q, ct_save_d;
`else
  logic         unused_cfg;
  assign unused_cfg = ^{Iv, Cbc};
`endif

  assign InRdy   = !buf_full_q && !RST;
  assign CfgRdy  = (state_q == IDLE) && !buf_full_q && !RST;
  assign in_hs   = InVld && InRdy;
  assign cfg_hs  = CfgLd && CfgRdy;
  assign issue   = (state_q == IDLE) && buf_full_q && !DesBsy && !RST;

  // The core's key schedule wraps back after 16 rounds, so Krdy rides only the first issue after a config.
  assign DesDrdy = issue;
  assign DesKrdy = issue && key_pend_q;
  assign DesKey  = key_q;
  assign DesEnc  = enc_q;
  assign DesEn   = 1'b1;

  assign OutData = out_q;
  assign OutVld  = (state_q == OUT) && !RST;
  assign Busy    = (buf_full_q || (state_q != IDLE)) && !RST;

`ifdef DES_CBC_EN
  assign DesDin  = (enc_q && cbc_q) ? (buf_q ^ chain_q) : buf_q;
`else
  assign DesDin  = buf_q;
`endif

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    key_d      = key_q;
    enc_d      = enc_q;
    key_pend_d = key_pend_q;
    out_d      = out_q;
`ifdef DES_CBC_EN
    cbc_d      = cbc_q;
    chain_d    = chain_q;
    ct_save_d  = ct_save_q;
`endif

    if (cfg_hs) begin
      key_d      = Key;
      enc_d      = Enc;
      key_pend_d = 1'b1;
`ifdef DES_CBC_EN
      cbc_d      = Cbc;
      chain_d    = Iv;
`endif
    end

    if (in_hs) begin
      buf_d      = InData;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d    = WAIT;
          buf_full_d = 1'b0;
          key_pend_d = 1'b0;
`ifdef DES_CBC_EN
          ct_save_d  = buf_q;
`endif
        end
      end
      WAIT: begin
        if (DesDvld) begin
          state_d = OUT;
`ifdef DES_CBC_EN
          if (enc_q) begin
            out_d = DesDout;
            if (cbc_q) chain_d = DesDout;
          end else if (cbc_q) begin
            out_d   = DesDout ^ chain_q;
            chain_d = ct_save_q;
          end else begin
            out_d = DesDout;
          end
`else
          out_d = DesDout;
`endif
        end
      end
      OUT: begin
        if (OutRdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      key_q      <= '0;
      enc_q      <= 1'b1;
      key_pend_q <= 1'b1;
      out_q      <= '0;
`ifdef DES_CBC_EN
      cbc_q      <= 1'b0;
      chain_q    <= '0;
      ct_save_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      key_q      <= key_d;
      enc_q      <= enc_d;
      key_pend_q <= key_pend_d;
      out_q      <= out_d;
`ifdef DES_CBC_EN
      cbc_q      <= cbc_d;
      chain_q    <= chain_d;
      ct_save_q  <= ct_save_d;
`endif
    end
  end

endmodule
